sm83_alu_seq: RTL and testbench

- Micro-sequencer directly upstream of the SM83 nibble ALU.
- Accepts one 8-bit arithmetic request (ADD/ADC/SUB/SBC/CP/INC/DEC) and drives the ALU's load, mux and carry controls through two 4-bit passes, low nibble then high nibble.
- Samples the ALU's carry, zero and bus outputs and returns the 8-bit result plus Z/N/H/C flags to the register-file/flag stage with a start/done handshake.

---
 rtl/sm83_alu_seq_if.sv | 14 +
 rtl/sm83_alu_seq.sv | 92 +++++++++
 tb/tb_sm83_alu_seq.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/sm83_alu_seq_if.sv
// sm83_alu_seq_if: request/response handshake between the flag stage and the ALU sequencer
interface sm83_alu_seq_if #(parameter int WORD_SIZE = 8);
  logic start;
  logic [2:0] op;
  logic [WORD_SIZE-1:0] opnd_a, opnd_b;
  logic [3:0] flags_in;
  logic busy, done, result_we, flags_we;
  logic [WORD_SIZE-1:0] result;
  logic [3:0] flags_out;
  modport master (output start, op, opnd_a, opnd_b, flags_in,
                  input busy, done, result, flags_out, result_we, flags_we);
  modport slave (input start, op, opnd_a, opnd_b, flags_in,
                 output busy, done, result, flags_out, result_we, flags_we);
endinterface

// File: rtl/sm83_alu_seq.sv
// sm83_alu_seq: drives the SM83 nibble ALU through low/high passes for one 8-bit arithmetic op
module sm83_alu_seq #(parameter int WORD_SIZE = 8) (
  input  logic clk,
  input  logic reset_n,
  sm83_alu_seq_if.slave req,
  output logic [WORD_SIZE-1:0] alu_din,
  output logic alu_load_a,
  output logic alu_load_b,
  output logic alu_load_b_zero,
  output logic alu_shift_oe,
  output logic alu_result_oe,
  output logic alu_op_low,
  output logic alu_op_b_high,
  output logic alu_negate,
  output logic alu_carry_in,
  input  logic alu_carry,
  input  logic alu_zero,
  input  logic [WORD_SIZE-1:0] alu_dout
);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, LO, HI, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] op_q;
  logic [WORD_SIZE-1:0] b_q;
  logic c_q, hc, accept, incdec, neg, cin0, wr_res, wr_flg;
  assign accept = req.start && (state == IDLE || state == DONE);
  assign incdec = op_q == 3'd5 || op_q == 3'd6;
  assign neg = op_q inside {3'd2, 3'd3, 3'd4, 3'd6};
  assign cin0 = op_q == 3'd1 ? c_q : op_q == 3'd3 ? !c_q : op_q inside {3'd2, 3'd4, 3'd5};
  assign wr_res = state == HI && op_q != 3'd4 && op_q != 3'd7;
  assign wr_flg = state == HI && op_q != 3'd7;
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE, DONE: state_nx = accept ? LOAD_A : IDLE;
      LOAD_A:     state_nx = LOAD_B;
      LOAD_B:     state_nx = LO;
      LO:         state_nx = HI;
      HI:         state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      op_q <= '0;
      b_q <= '0;
      c_q <= 1'b0;
      hc <= 1'b0;
      alu_din <= '0;
      alu_load_a <= 1'b0;
      alu_load_b <= 1'b0;
      alu_load_b_zero <= 1'b0;
      alu_shift_oe <= 1'b0;
      alu_result_oe <= 1'b0;
      alu_op_low <= 1'b0;
      alu_op_b_high <= 1'b0;
      alu_negate <= 1'b0;
      alu_carry_in <= 1'b0;
      req.busy <= 1'b0;
      req.done <= 1'b0;
      req.result_we <= 1'b0;
      req.flags_we <= 1'b0;
      req.result <= '0;
      req.flags_out <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q <= req.op;
        b_q <= req.opnd_b;
        c_q <= req.flags_in[0];
      end
      if (state == LO) hc <= alu_carry;
      // operand A goes out the same edge it is accepted, so it comes straight from the port
      alu_din <= state_nx == LOAD_A ? req.opnd_a : (state_nx == LOAD_B && !incdec) ? b_q : '0;
      alu_load_a <= state_nx == LOAD_A;
      alu_load_b <= state_nx == LOAD_B && !incdec;
      alu_load_b_zero <= state_nx == LOAD_B && incdec;
      alu_shift_oe <= state_nx == LOAD_A || (state_nx == LOAD_B && !incdec);
      alu_op_low <= state_nx == LO;
      alu_op_b_high <= state_nx == HI;
      alu_result_oe <= state_nx == HI;
      alu_negate <= (state_nx == LO || state_nx == HI) && neg;
      alu_carry_in <= state_nx == LO ? cin0 : state_nx == HI ? alu_carry : 1'b0;
      req.busy <= state_nx inside {LOAD_A, LOAD_B, LO, HI};
      req.done <= state_nx == DONE;
      req.result_we <= wr_res;
      req.flags_we <= wr_flg;
      if (wr_res) req.result <= alu_dout;
      if (wr_flg) req.flags_out <= {alu_zero, neg, neg ? !hc : hc, incdec ? c_q : neg ? !alu_carry : alu_carry};
    end
  end
endmodule

// File: tb/tb_sm83_alu_seq.sv
// tb_sm83_alu_seq: scoreboard bench for sm83_alu_seq driving a behavioural nibble ALU
module tb_sm83_alu_seq;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [7:0] alu_din, alu_dout;
  logic alu_load_a, alu_load_b, alu_load_b_zero, alu_shift_oe, alu_result_oe;
  logic alu_op_low, alu_op_b_high, alu_negate, alu_carry_in, alu_carry, alu_zero;
  sm83_alu_seq_if bus();
  sm83_alu_seq dut (
    .clk(clk), .reset_n(reset_n), .req(bus),
    .alu_din(alu_din), .alu_load_a(alu_load_a), .alu_load_b(alu_load_b),
    .alu_load_b_zero(alu_load_b_zero), .alu_shift_oe(alu_shift_oe),
    .alu_result_oe(alu_result_oe), .alu_op_low(alu_op_low), .alu_op_b_high(alu_op_b_high),
    .alu_negate(alu_negate), .alu_carry_in(alu_carry_in), .alu_carry(alu_carry),
    .alu_zero(alu_zero), .alu_dout(alu_dout)
  );
  always #5 clk = ~clk;
  logic [7:0] ra, rb;
  logic [3:0] rlo, an, bn;
  logic [4:0] sum;
  always @(negedge clk) begin
    if (alu_load_a) ra <= alu_din;
    if (alu_load_b) rb <= alu_din;
    if (alu_load_b_zero) rb <= 8'h00;
    if (alu_op_low) rlo <= sum[3:0];
  end
  assign an = alu_op_low ? ra[3:0] : ra[7:4];
  assign bn = (alu_op_b_high ? rb[7:4] : rb[3:0]) ^ {4{alu_negate}};
  assign sum = {1'b0, an} + {1'b0, bn} + {4'b0, alu_carry_in};
  assign alu_carry = sum[4];
  assign alu_dout = alu_result_oe ? {sum[3:0], rlo} : 8'h00;
  assign alu_zero = alu_dout == 8'h00;
  logic [16:0] ctl;
  assign ctl = {alu_din, alu_load_a, alu_load_b, alu_load_b_zero, alu_shift_oe, alu_result_oe,
                alu_op_low, alu_op_b_high, alu_negate, alu_carry_in};
  typedef struct {logic [7:0] r; logic [3:0] f; logic rwe; logic fwe; int t0;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  int errors = 0, checks = 0, cyc = 0;
  logic [7:0] last_r = 8'h00;
  logic [3:0] last_f = 4'h0;
  logic prev_done = 1'b0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic [3:0] f);
    exp_t e;
    int ai, bi, ci, r;
    bit h, cy, n;
    ai = int'(a);
    bi = int'(b);
    cy = f[0];
    ci = 0;
    r = 0;
    h = 1'b0;
    n = 1'b0;
    case (op)
      3'd0, 3'd1: begin
        ci = op == 3'd1 ? int'(f[0]) : 0;
        r = ai + bi + ci;
        h = (ai % 16) + (bi % 16) + ci > 15;
        cy = r > 255;
      end
      3'd2, 3'd3, 3'd4: begin
        ci = op == 3'd3 ? int'(f[0]) : 0;
        r = ai - bi - ci;
        h = (ai % 16) < (bi % 16) + ci;
        cy = ai < bi + ci;
        n = 1'b1;
      end
      3'd5: begin
        r = ai + 1;
        h = ai % 16 == 15;
      end
      3'd6: begin
        r = ai - 1;
        h = ai % 16 == 0;
        n = 1'b1;
      end
      default: ;
    endcase
    e.t0 = 0;
    e.rwe = op != 3'd4 && op != 3'd7;
    e.fwe = op != 3'd7;
    e.r = e.rwe ? r[7:0] : last_r;
    e.f = e.fwe ? {r[7:0] == 8'h00, n, h, cy} : last_f;
    return e;
  endfunction
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] f, input bit track);
    exp_t e;
    bus.op = op;
    bus.opnd_a = a;
    bus.opnd_b = b;
    bus.flags_in = f;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    if (track) begin
      e = model(op, a, b, f);
      e.t0 = cyc;
      last_r = e.r;
      last_f = e.f;
      q.push_back(e);
    end
  endtask
  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 20);
    chk("done_timeout", 32'(bus.done), 1);
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  // scoreboard: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (bus.done) begin
      chk("expected_pending", 32'(q.size() > 0), 1);
      chk("done_pulse_width", 32'(prev_done), 0);
      chk("ctl_in_done", 32'(ctl), 0);
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        chk("result", 32'(bus.result), 32'(mon_e.r));
        chk("flags", 32'(bus.flags_out), 32'(mon_e.f));
        chk("result_we", 32'(bus.result_we), 32'(mon_e.rwe));
        chk("flags_we", 32'(bus.flags_we), 32'(mon_e.fwe));
        chk("latency", 32'(cyc - mon_e.t0), 4);
      end
    end
    prev_done <= bus.done;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.start = 1'b0;
    bus.op = 3'd0;
    bus.opnd_a = 8'h00;
    bus.opnd_b = 8'h00;
    bus.flags_in = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst_out", 32'({bus.busy, bus.done, bus.result, bus.flags_out, bus.result_we, bus.flags_we}), 0);
    chk("rst_ctl", 32'(ctl), 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 0);
    // ADD 0x3A+0xC6 with a phase-by-phase look at the ALU controls
    issue(3'd0, 8'h3A, 8'hC6, 4'h0, 1'b1);
    @(negedge clk);
    chk("load_a_phase", 32'({bus.busy, alu_load_a, alu_shift_oe, alu_din}), 32'({3'b111, 8'h3A}));
    @(negedge clk);
    chk("load_b_phase", 32'({alu_load_b, alu_shift_oe, alu_load_a, alu_din}), 32'({3'b110, 8'hC6}));
    @(negedge clk);
    chk("lo_phase", 32'({alu_op_low, alu_op_b_high, alu_negate, alu_carry_in, alu_result_oe}), 32'(5'b10000));
    @(negedge clk);
    chk("hi_phase", 32'({alu_op_low, alu_op_b_high, alu_negate, alu_carry_in, alu_result_oe}), 32'(5'b01011));
    wait_done();
    chk("add_flags_plan", 32'({bus.result, bus.flags_out}), 32'({8'h00, 4'b1011}));
    issue(3'd2, 8'h10, 8'h01, 4'h0, 1'b1);
    wait_done();
    chk("sub_plan", 32'({bus.result, bus.flags_out}), 32'({8'h0F, 4'b0110}));
    issue(3'd3, 8'h00, 8'h00, 4'h1, 1'b1);
    wait_done();
    chk("sbc_plan", 32'({bus.result, bus.flags_out}), 32'({8'hFF, 4'b0111}));
    issue(3'd5, 8'hFF, 8'h5A, 4'h0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("inc_load_b_zero", 32'({alu_load_b_zero, alu_load_b, alu_shift_oe}), 32'(3'b100));
    wait_done();
    chk("inc_plan", 32'({bus.result, bus.flags_out}), 32'({8'h00, 4'b1010}));
    issue(3'd6, 8'h01, 8'h77, 4'h1, 1'b1);
    wait_done();
    chk("dec_plan", 32'({bus.result, bus.flags_out}), 32'({8'h00, 4'b1101}));
    issue(3'd1, 8'h12, 8'h34, 4'h1, 1'b1);
    wait_done();
    issue(3'd4, 8'h42, 8'h42, 4'h0, 1'b1);
    wait_done();
    chk("cp_plan", 32'({bus.result, bus.flags_out}), 32'({8'h47, 4'b1100}));
    issue(3'd7, 8'h12, 8'h34, 4'hF, 1'b1);
    wait_done();
    // back-to-back: second start lands while the first is in DONE
    issue(3'd0, 8'h0F, 8'h01, 4'h0, 1'b1);
    wait_done();
    issue(3'd2, 8'h05, 8'h07, 4'h0, 1'b1);
    chk("b2b_no_gap", 32'({bus.busy, alu_load_a, alu_din}), 32'({2'b11, 8'h05}));
    wait_done();
    // a start during LO must not spawn a second operation
    issue(3'd1, 8'hFF, 8'h00, 4'h1, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 bus.op = 3'd5;
    bus.opnd_a = 8'h7F;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done();
    repeat (8) @(negedge clk);
    chk("lo_start_ignored", 32'({bus.busy, q.size() == 0}), 32'(2'b01));
    for (int i = 0; i < 6; i++) begin
      issue(3'($urandom_range(0, 6)), 8'($urandom), 8'($urandom), 4'($urandom), 1'b1);
      wait_done();
    end
    issue(3'd0, 8'h55, 8'h11, 4'h0, 1'b1);
    wait_done();
    // reset asserted while the next operation is in HI
    issue(3'd0, 8'h80, 8'h01, 4'h0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_out", 32'({bus.busy, bus.done, bus.result, bus.flags_out, bus.result_we, bus.flags_we}), 0);
    chk("abort_ctl", 32'(ctl), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    last_r = 8'h00;
    last_f = 4'h0;
    repeat (6) @(negedge clk);
    chk("abort_no_done", 32'({bus.done, bus.busy, bus.result}), 0);
    issue(3'd0, 8'h01, 8'h01, 4'h0, 1'b1);
    wait_done();
    chk("post_reset_add", 32'({bus.result, bus.flags_out}), 32'({8'h02, 4'b0000}));
    repeat (3) @(negedge clk);
    chk("drain", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
